hzu_ctrl: RTL and testbench
===========================

Name: hzu_ctrl

Overview:
Parametrised pipeline hazard/control unit for an N-stage in-order core. It is the next generation of the fixed 5-stage stall/flush encoder. It derives per-stage stall, flush and force-flush vectors from a per-stage hazard vector and indexed redirect requests. It adds sequential behaviour that the combinational encoder lacks: a pending-redirect latch, a pipeline drain FSM (fence/CSR serialisation) and a stall watchdog. It sits between the stage datapaths and the pipeline registers.

Parameters:
STAGES, 5, number of pipeline stages (index 0 = fetch, STAGES-1 = writeback); legal range 3..16
WDOG_W, 8, stall watchdog counter width
CNT_W, 32, performance counter width (used only with the optional feature)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
inst_valid  in  STAGES  bit k = stage k holds a valid instruction
haz_req  in  STAGES  bit k = stage k cannot advance this cycle
redirect_req  in  1  single-cycle pulse: control-flow redirect resolved
redirect_stage  in  $clog2(STAGES)  stage index that resolved the redirect
drain_req  in  1  pulse: drain all stages above 0 before issuing further
stall_timeout_clr  in  1  clears stall_timeout
stall  out  STAGES  per-stage hold
flush  out  STAGES  per-stage bubble insert (includes flush_force)
flush_force  out  STAGES  per-stage unconditional kill (redirect)
drain_busy  out  1  drain FSM in DRAIN
drain_done  out  1  one-cycle pulse, drain complete
stall_timeout  out  1  sticky, stage 0 stalled for 2^WDOG_W-1 consecutive cycles
perf_stall_cnt  out  CNT_W  optional feature only
perf_flush_cnt  out  CNT_W  optional feature only

Behaviour:
- Hazard encode (combinational): let k = index of the highest set bit of haz_req.
  - stall[j]=1 for all j<=k.
  - flush[min(k+1,STAGES-1)]=1.
  - If haz_req is all zeros, there is no hazard contribution.
- Redirect acceptance: a redirect is accepted in a cycle when redirect_req=1 and stall[redirect_stage]=0.
  - Accepted: flush_force[j]=1 for all j<redirect_stage, in the same cycle.
  - redirect_stage=0: no force-flush.
- Pending redirect: if redirect_req=1 while stall[redirect_stage]=1, latch pend_vld=1 and pend_stage=redirect_stage.
  - The pending redirect is applied in the first cycle with stall[pend_stage]=0; pend_vld clears that cycle.
  - A new pulse while pending replaces pend_stage only if its index is greater (older instruction wins).
  - A live pulse and a pending redirect in the same cycle: apply the higher index; the loser is discarded.
- flush = hazard_flush | drain_flush | flush_force. The stall vector is still reported during force-flush; consumers give flush priority.
- Drain FSM, states IDLE, DRAIN, DONE:
  - IDLE -> DRAIN on drain_req.
  - In DRAIN: stall[0]=1 and flush[1]=1, ORed with hazard outputs. drain_busy=1.
  - DRAIN -> DONE when inst_valid[STAGES-1:1]==0. Evaluated the same cycle, so already-empty drains take 1 cycle in DRAIN.
  - DONE: drain_done=1 for one cycle, then -> IDLE.
  - drain_req is ignored outside IDLE.
  - Redirects are accepted normally during DRAIN.
- Watchdog:
  - wdog_cnt increments each cycle stall[0]=1 and clears when stall[0]=0; it saturates at all-ones.
  - When the count reaches all-ones, stall_timeout sets.
  - stall_timeout_clr clears stall_timeout and wins over a same-cycle set.
- Reset (async): FSM=IDLE, pend_vld=0, wdog_cnt=0, stall_timeout=0, drain_busy=0, drain_done=0, perf counters=0.
  - During reset, stall/flush/flush_force reflect only the combinational hazard and live redirect terms (no pending or drain terms).
  - Reset mid-drain or mid-pending abandons that operation without a done pulse.

Optional Feature:
HZU_PERF_CNT_EN
- Defined:
  - perf_stall_cnt increments each cycle stall[0]=1.
  - perf_flush_cnt increments each cycle any flush_force bit is set.
  - Both counters wrap modulo 2^CNT_W.
- Undefined: both outputs are tied to 0 and no counter flops are instantiated.

Test Plan:
- STAGES=5, haz_req=5'b00100 -> stall=00111, flush=01000, flush_force=00000.
- haz_req=5'b10000 -> stall=11111, flush=10000.
- redirect_req pulse, redirect_stage=2, no hazard -> flush_force=00011, flush=00011 in the same cycle.
- haz_req=00100 for 3 cycles; redirect pulse stage=2 in cycle 1 -> no force in cycles 1-3; flush_force=00011 in cycle 4 (haz cleared), pend_vld then 0.
- drain_req with inst_valid=11110, valids retired one stage per cycle -> drain_busy high until inst_valid[4:1]=0, drain_done high exactly one cycle after, stall[0]=1 throughout DRAIN.
- WDOG_W=3, haz_req[0]=1 held -> stall_timeout sets after 7 stall cycles. Assert stall_timeout_clr with haz held: timeout clears and stays clear, since the counter is saturated and re-sets only after the count restarts from 0.

Source files
------------

// File: rtl/hzu_ctrl.sv
// rtl/hzu_ctrl.sv - pipeline hazard/control unit: stall/flush encode, pending redirect, drain FSM, stall watchdog
// Optional performance counters enabled by defining HZU_PERF_CNT_EN.
module hzu_ctrl #(
  parameter int STAGES = 5,
  parameter int WDOG_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STAGES-1:0]         inst_valid,
  input  logic [STAGES-1:0]         haz_req,
  input  logic                      redirect_req,
  input  logic [$clog2(STAGES)-1:0] redirect_stage,
  input  logic                      drain_req,
  input  logic                      stall_timeout_clr,
  output logic [STAGES-1:0]         stall,
  output logic [STAGES-1:0]         flush,
  output logic [STAGES-1:0]         flush_force,
  output logic                      drain_busy,
  output logic                      drain_done,
  output logic                      stall_timeout,
  output logic [CNT_W-1:0]          perf_stall_cnt,
  output logic [CNT_W-1:0]          perf_flush_cnt
);
  localparam int SW = $clog2(STAGES);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_DONE} drain_st_t;

  drain_st_t         state_q, state_d;
  logic              pend_vld_q, pend_vld_d;
  logic [SW-1:0]     pend_stage_q, pend_stage_d;
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              stall_timeout_q, stall_timeout_d;

  logic [STAGES-1:0] haz_stall, haz_flush, drain_stall, drain_flush, stall_all, force_v;
  logic              run, cand_vld, cand_stalled, accept;
  logic [SW-1:0]     cand_stage;
  logic              unused_inst_valid0;

  assign unused_inst_valid0 = inst_valid[0];

  // Stall runs from stage 0 up to the highest hazard; the bubble goes just above it.
  always_comb begin
    haz_stall = '0;
    haz_flush = '0;
    run       = 1'b0;
    for (int j = STAGES - 1; j >= 0; j--) begin
      run          = run | haz_req[j];
      haz_stall[j] = run;
    end
    for (int j = 1; j < STAGES - 1; j++) begin
      haz_flush[j] = haz_stall[j-1] & ~haz_stall[j];
    end
    haz_flush[STAGES-1] = haz_req[STAGES-1] | (haz_stall[STAGES-2] & ~haz_stall[STAGES-1]);
  end

  always_comb begin
    drain_stall = '0;
    drain_flush = '0;
    if (state_q == ST_DRAIN) begin
      drain_stall[0] = 1'b1;
      drain_flush[1] = 1'b1;
    end
    stall_all = haz_stall | drain_stall;
  end

  // Live and pending redirects merge into one candidate; the older (higher) stage wins.
  always_comb begin
    cand_vld   = redirect_req | pend_vld_q;
    cand_stage = redirect_stage;
    if (pend_vld_q && (!redirect_req || (pend_stage_q > redirect_stage))) begin
      cand_stage = pend_stage_q;
    end
    cand_stalled = 1'b0;
    for (int j = 0; j < STAGES; j++) begin
      if (SW'(j) == cand_stage) cand_stalled = stall_all[j];
    end
    accept  = cand_vld & ~cand_stalled;
    force_v = '0;
    for (int j = 0; j < STAGES; j++) begin
      force_v[j] = accept && (SW'(j) < cand_stage);
    end
    pend_vld_d   = cand_vld & cand_stalled;
    pend_stage_d = cand_vld ? cand_stage : pend_stage_q;
  end

  // Timeout sets only on the step into saturation, so a clear sticks while the count stays pinned.
  always_comb begin
    wdog_cnt_d = '0;
    if (stall_all[0]) begin
      wdog_cnt_d = (wdog_cnt_q == '1) ? wdog_cnt_q : wdog_cnt_q + 1'b1;
    end
    stall_timeout_d = stall_timeout_q | ((wdog_cnt_d == '1) && (wdog_cnt_q != '1));
    if (stall_timeout_clr) stall_timeout_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (drain_req) state_d = ST_DRAIN;
      ST_DRAIN: if (inst_valid[STAGES-1:1] == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      pend_vld_q      <= 1'b0;
      pend_stage_q    <= '0;
      wdog_cnt_q      <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pend_vld_q      <= pend_vld_d;
      pend_stage_q    <= pend_stage_d;
      wdog_cnt_q      <= wdog_cnt_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  assign stall         = stall_all;
  assign flush         = haz_flush | drain_flush | force_v;
  assign flush_force   = force_v;
  assign drain_busy    = (state_q == ST_DRAIN);
  assign drain_done    = (state_q == ST_DONE);
  assign stall_timeout = stall_timeout_q;

`ifdef HZU_PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + CNT_W'(stall_all[0]);
    perf_flush_d = perf_flush_q + CNT_W'(|force_v);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hzu_ctrl.sv
// tb/tb_hzu_ctrl.sv - scoreboard bench for hzu_ctrl against a behavioural reference model
module tb_hzu_ctrl;
  localparam int S  = 5;
  localparam int WW = 3;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [S-1:0]  inst_valid = '0, haz_req = '0;
  logic          redirect_req = 1'b0, drain_req = 1'b0, stall_timeout_clr = 1'b0;
  logic [2:0]    redirect_stage = '0;
  logic [S-1:0]  stall, flush, flush_force;
  logic          drain_busy, drain_done, stall_timeout;
  logic [CW-1:0] perf_stall_cnt, perf_flush_cnt;

  hzu_ctrl #(.STAGES(S), .WDOG_W(WW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .haz_req(haz_req),
    .redirect_req(redirect_req), .redirect_stage(redirect_stage),
    .drain_req(drain_req), .stall_timeout_clr(stall_timeout_clr),
    .stall(stall), .flush(flush), .flush_force(flush_force),
    .drain_busy(drain_busy), .drain_done(drain_done), .stall_timeout(stall_timeout),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [S-1:0]  stall;
    logic [S-1:0]  flush;
    logic [S-1:0]  frc;
    logic          busy;
    logic          done;
    logic          tmo;
    logic [CW-1:0] ps;
    logic [CW-1:0] pf;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: drain mode 0=idle 1=draining 2=done pulse
  int          m_mode, m_pstage, m_wd;
  bit          m_pend, m_tmo;
  logic [CW-1:0] m_ps, m_pf;

  task automatic model_reset();
    m_mode = 0; m_pend = 0; m_pstage = 0; m_wd = 0; m_tmo = 0; m_ps = '0; m_pf = '0;
  endtask

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall", CW'(stall), CW'(e.stall));
      chk("flush", CW'(flush), CW'(e.flush));
      chk("flush_force", CW'(flush_force), CW'(e.frc));
      chk("drain_busy", CW'(drain_busy), CW'(e.busy));
      chk("drain_done", CW'(drain_done), CW'(e.done));
      chk("stall_timeout", CW'(stall_timeout), CW'(e.tmo));
      chk("perf_stall_cnt", perf_stall_cnt, e.ps);
      chk("perf_flush_cnt", perf_flush_cnt, e.pf);
    end
  end

  task automatic cycle(input bit r, input logic [S-1:0] hz, input logic [S-1:0] iv,
                       input bit rr, input int rs, input bit dr, input bit clr);
    int k, c, old, wmax;
    logic [S-1:0] st, fl, fr;
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; haz_req = hz; inst_valid = iv; redirect_req = rr;
    redirect_stage = 3'(rs); drain_req = dr; stall_timeout_clr = clr;
    if (r) model_reset();
    k = -1;
    for (int i = 0; i < S; i++) if (hz[i]) k = i;
    st = '0; fl = '0; fr = '0;
    if (k >= 0) begin
      for (int j = 0; j <= k; j++) st[j] = 1'b1;
      fl[(k + 1 > S - 1) ? S - 1 : k + 1] = 1'b1;
    end
    if (m_mode == 1) begin st[0] = 1'b1; fl[1] = 1'b1; end
    c = -1;
    if (rr) c = rs;
    if (m_pend && m_pstage > c) c = m_pstage;
    if (c >= 0) begin
      if (!st[c]) begin
        for (int j = 0; j < c; j++) fr[j] = 1'b1;
        m_pend = 0;
      end else begin
        m_pend = 1; m_pstage = c;
      end
    end
    fl = fl | fr;
    e.stall = st; e.flush = fl; e.frc = fr;
    e.busy = (m_mode == 1); e.done = (m_mode == 2); e.tmo = m_tmo;
`ifdef HZU_PERF_CNT_EN
    e.ps = m_ps; e.pf = m_pf;
`else
    e.ps = '0; e.pf = '0;
`endif
    q.push_back(e);
    m_ps = m_ps + CW'(st[0]);
    m_pf = m_pf + CW'(fr != 0);
    wmax = (1 << WW) - 1;
    old = m_wd;
    m_wd = st[0] ? ((m_wd < wmax) ? m_wd + 1 : wmax) : 0;
    if (st[0] && old == wmax - 1) m_tmo = 1;
    if (clr) m_tmo = 0;
    case (m_mode)
      0: if (dr) m_mode = 1;
      1: if (iv[S-1:1] == 0) m_mode = 2;
      default: m_mode = 0;
    endcase
    if (r) model_reset();
  endtask

  initial begin
    logic [S-1:0] hz, iv;
    model_reset();
    cycle(1, 5'b00000, 5'b00000, 0, 0, 0, 0);
    cycle(1, 5'b00100, 5'b00000, 1, 2, 0, 0);
    cycle(0, 5'b00000, 5'b00000, 0, 0, 0, 0);
    cycle(0, 5'b00100, 5'b00000, 0, 0, 0, 0);
    cycle(0, 5'b10000, 5'b00000, 0, 0, 0, 0);
    cycle(0, 5'b00000, 5'b00000, 1, 2, 0, 0);
    cycle(0, 5'b00000, 5'b00000, 1, 0, 0, 0);
    cycle(0, 5'b00100, 5'b00000, 1, 2, 0, 0);
    cycle(0, 5'b00100, 5'b00000, 0, 0, 0, 0);
    cycle(0, 5'b00100, 5'b00000, 0, 0, 0, 0);
    cycle(0, 5'b00000, 5'b00000, 0, 0, 0, 0);
    cycle(0, 5'b00000, 5'b00000, 0, 0, 0, 0);
    cycle(0, 5'b00000, 5'b11110, 0, 0, 1, 0);
    cycle(0, 5'b00000, 5'b11100, 0, 0, 0, 0);
    cycle(0, 5'b00000, 5'b11000, 0, 0, 0, 0);
    cycle(0, 5'b00000, 5'b10000, 0, 0, 0, 0);
    cycle(0, 5'b00000, 5'b00000, 0, 0, 0, 0);
    cycle(0, 5'b00000, 5'b00000, 0, 0, 0, 0);
    cycle(0, 5'b00000, 5'b00000, 0, 0, 0, 0);
    cycle(0, 5'b00000, 5'b00000, 0, 0, 1, 0);
    cycle(0, 5'b00000, 5'b00000, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 5'b00001, 5'b00000, 0, 0, 0, 0);
    cycle(0, 5'b00001, 5'b00000, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 5'b00001, 5'b00000, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle(0, (i == 0) ? 5'b00000 : 5'b00001, 5'b00000, 0, 0, 0, 0);
    cycle(0, 5'b00000, 5'b01110, 0, 0, 1, 0);
    cycle(0, 5'b01000, 5'b01110, 1, 4, 0, 0);
    cycle(1, 5'b00000, 5'b01110, 0, 0, 0, 0);
    cycle(0, 5'b00000, 5'b00000, 0, 0, 0, 0);
    cycle(0, 5'b00000, 5'b00000, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      hz = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b00000;
      iv = ($urandom_range(0, 2) == 0) ? 5'b00000 : 5'($urandom);
      cycle(($urandom_range(0, 299) == 0), hz, iv, ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, S - 1)), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 15) == 0));
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
